orient_hist_acc: RTL and testbench



---
 rtl/orient_hist_acc_if.sv | 26 ++
 rtl/orient_hist_acc.sv | 101 ++++++++++
 tb/tb_orient_hist_acc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/orient_hist_acc_if.sv
// Sample-in / result-out handshake bundle for the orientation histogram accumulator.
interface orient_hist_acc_if #(
  parameter int unsigned BIN_W = 5,
  parameter int unsigned MAG_W = 12,
  parameter int unsigned ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic [MAG_W-1:0] in_mag;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic [ACC_W-1:0] out_peak;

  modport master (
    output in_valid, in_bin, in_mag, in_last, out_ready,
    input  in_ready, out_valid, out_bin, out_peak
  );

  modport slave (
    input  in_valid, in_bin, in_mag, in_last, out_ready,
    output in_ready, out_valid, out_bin, out_peak
  );
endinterface

// File: rtl/orient_hist_acc.sv
// Magnitude-weighted 2^BIN_W-bin orientation histogram; after each window the
// bins are scanned for the dominant orientation, which is reported and then cleared.
module orient_hist_acc #(
  parameter int unsigned BIN_W = 5,
  parameter int unsigned MAG_W = 12,
  parameter int unsigned ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  orient_hist_acc_if.slave  bus,
  output logic              busy
);

  localparam int unsigned NBINS = 1 << BIN_W;

  typedef enum logic [1:0] {
    ACC,
    SCAN,
    OUT
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] hist [NBINS];
  logic [BIN_W-1:0] scan_idx;
  logic [BIN_W-1:0] max_bin;
  logic [ACC_W-1:0] max_val;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_sum;
  logic             in_fire;
  logic             out_fire;

  // Carry out of the widened add means the bin would wrap; pin it at full scale.
  always_comb begin
    sum     = {1'b0, hist[bus.in_bin]} + (ACC_W + 1)'(bus.in_mag);
    sat_sum = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      ACC: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (scan_idx == BIN_W'(NBINS - 1)) state_nxt = OUT;
      end
      OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign bus.out_bin  = max_bin;
  assign bus.out_peak = max_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NBINS; i++) hist[i] <= '0;
    end else if (out_fire) begin
      for (int unsigned i = 0; i < NBINS; i++) hist[i] <= '0;
    end else if (in_fire) begin
      hist[bus.in_bin] <= sat_sum;
    end
  end

  // Bin 0 seeds the running max unconditionally; later bins replace it only when
  // strictly greater, so ties keep the lowest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      scan_idx <= '0;
      max_bin  <= '0;
      max_val  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (scan_idx == '0 || hist[scan_idx] > max_val) begin
          max_bin <= scan_idx;
          max_val <= hist[scan_idx];
        end
      end
      if (out_fire) begin
        scan_idx <= '0;
        max_bin  <= '0;
        max_val  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_orient_hist_acc.sv
// Directed bench for orient_hist_acc with hand-computed expected results.
module tb_orient_hist_acc;

  localparam int unsigned BIN_W = 5;
  localparam int unsigned MAG_W = 12;
  localparam int unsigned ACC_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  orient_hist_acc_if #(.BIN_W(BIN_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) bus ();

  orient_hist_acc #(.BIN_W(BIN_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int b, input int m, input bit l);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = BIN_W'(b);
    bus.in_mag   = MAG_W'(m);
    bus.in_last  = l;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called #1 after the handshake edge of the in_last sample.
  task automatic wait_out(input string tag);
    int n = 0;
    chk({tag, "_busy_scan"}, 32'(busy), 1);
    chk({tag, "_ready_scan"}, 32'(bus.in_ready), 0);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32);
  endtask

  task automatic take(input string tag, input int b, input int p);
    chk({tag, "_bin"}, 32'(bus.out_bin), b);
    chk({tag, "_peak"}, 32'(bus.out_peak), p);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_bin    = '0;
    bus.in_mag    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_bin", 32'(bus.out_bin), 0);
    chk("rst_out_peak", 32'(bus.out_peak), 0);
    chk("rst_busy", 32'(busy), 0);

    // Basic window: bin 3 = 100 + 25, bin 7 = 50.
    send(3, 100, 1'b0);
    send(7, 50, 1'b0);
    send(3, 25, 1'b1);
    wait_out("basic");
    take("basic", 3, 125);

    // Tie resolves to lower index; inputs offered during SCAN/OUT are ignored.
    send(9, 200, 1'b0);
    send(2, 200, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = 5'd9;
    bus.in_mag   = 12'd1000;
    bus.in_last  = 1'b1;
    wait_out("tie");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take("tie", 2, 200);

    // Saturation: 300 * 4095 exceeds 2^20-1.
    for (int i = 0; i < 300; i++) send(31, 4095, i == 299);
    wait_out("sat");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_bin", 32'(bus.out_bin), 31);
      chk("bp_peak", 32'(bus.out_peak), 1048575);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    take("sat", 31, 1048575);

    // Histogram must have cleared on the previous result handshake.
    send(0, 1, 1'b1);
    wait_out("clear");
    take("clear", 0, 1);

    // Empty window.
    send(17, 0, 1'b1);
    wait_out("empty");
    take("empty", 0, 0);

    // Reset during SCAN at T+10 drops the pending result.
    send(4, 9, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_out", seen, 0);
    send(5, 7, 1'b1);
    wait_out("post_rst");
    take("post_rst", 5, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule
